numpad_scanner: RTL and testbench
=================================

Name: numpad_scanner

Overview:
- Drives the 4x4 numpad matrix and produces the 5-bit key code that the calculator top-level control logic consumes.
- Scans columns active-low one at a time and samples rows through a synchronizer.
- Debounces press and release.
- Emits exactly one single-cycle code pulse per physical press, so digit-entry and push/operator actions fire once per keystroke.

Parameters:
- SETTLE_CYCLES, 16, cycles between changing the driven column and sampling rows (min 2).
- DEBOUNCE_CYCLES, 500000, cycles a row pattern must be stable to accept a press or release (10 ms at 50 MHz; min 1).
- REPEAT_DELAY, 25000000, cycles held before the first auto-repeat pulse (only with the optional feature).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (only with the optional feature).

Ports:
- clock  input  1  50 MHz system clock.
- reset  input  1  Synchronous, active-high.
- rows  input  4  Matrix rows, active-low, externally pulled up, asynchronous to clock.
- columns  output  4  Matrix column drive, active-low, exactly one bit low at all times.
- value  output  5  Key code pulse: {1'b1, col[1:0], row[1:0]} for one cycle, else 5'b00000.

Behaviour:
- Reset (clock edge with reset=1): state=SCAN, column index 0, columns=4'b1110, value=0, all counters cleared, synchronizer flops = 4'b1111. Reset mid-press abandons the key; no pulse is emitted.
- Input path: rows pass through a 2-flop synchronizer (rows_s). All decisions use rows_s, so press-to-detect latency includes 2 cycles.
- Code map: value[3:2]=column index, value[1:0]=row index.
  - col0 → 1, 4, 7, 0 (rows 0–3).
  - col1 → 2, 5, 8, (row3 unused).
  - col2 → 3, 6, 9, (row3).
  - col3 → A, B, C, D.
  - Example: key 1 = 5'b10000, A = 5'b11100, D = 5'b11111.
- SCAN:
  - Count SETTLE_CYCLES after each column change, then sample rows_s.
  - All high: advance column index (3 wraps to 0), update columns, restart the settle count.
  - Any low: latch the lowest-index low row as the candidate and the pattern, go to DEB_PRESS.
- DEB_PRESS (column held):
  - Pattern unchanged for DEBOUNCE_CYCLES consecutive cycles: emit code for exactly 1 cycle, go to HELD.
  - Pattern changes: restart the count with the new pattern.
  - Pattern goes all-high: return to SCAN on the same column (no pulse).
- HELD: column held, value=0. rows_s all-high → DEB_RELEASE.
- DEB_RELEASE:
  - rows_s all-high for DEBOUNCE_CYCLES consecutive cycles: advance column, go to SCAN.
  - Any low row: return to HELD.
- Simultaneous keys:
  - Same column: lowest row wins.
  - Different columns: the first column reached in scan order wins. Other keys are ignored until full release of the held column.
  - Keys in other columns are invisible while a column is held.
- Output guarantees:
  - value is non-zero for exactly one cycle per accepted press.
  - Two consecutive clock cycles are never both non-zero.
  - Without the optional feature, value is never asserted outside the DEB_PRESS→HELD transition.
- Counters: width = clog2(max parameter + 1); no wrap (saturate/clear on state change).

Optional Feature:
- Macro NUMPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs; after REPEAT_DELAY cycles emit the held code for 1 cycle, then every REPEAT_PERIOD cycles while still held.
  - Repeat applies only to digit codes (value[4]=1 and not col3). Operator keys A–D never repeat.
  - The counter clears on leaving HELD.
- Undefined: no repeat logic or counter is instantiated; HELD emits nothing.

Decomposition:
- Package numpad_pkg:
  - typedef scan_state_e {SCAN, DEB_PRESS, HELD, DEB_RELEASE}.
  - Constants KEY_NONE=5'b00000, KEY_EQ=5'b11100, KEY_ADD=5'b11101, KEY_SUB=5'b11110, KEY_MUL=5'b11111.
  - Function key_code(col, row).
- One natural sub-module: sync_2ff (parameterized width, reset value all-ones) for the rows synchronizer.

Test Plan (SETTLE_CYCLES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset with rows=4'b1111 → columns=4'b1110, value=0. Columns then cycles 1110→1101→1011→0111→1110 every 3 cycles.
- Hold rows[0] low only while columns==4'b1110, stable 10 cycles then release → exactly one cycle value=5'b10000, no further pulses.
- Press D (col3, row3), bouncing 3 times with <4-cycle glitches before settling → exactly one value=5'b11111 after the final 4 stable cycles.
- Press 5 (col1 row1) and 8 (col1 row2) together → single pulse 5'b10101. Releasing 5 while 8 is held yields no pulse. Full release then a fresh press of 8 → 5'b10110.
- Assert reset during DEB_PRESS with a key held → value stays 0. After reset, columns=4'b1110 and the key is re-detected only once its column is scanned.
- With NUMPAD_AUTOREPEAT_EN, hold key 1 for 50 cycles → pulses 5'b10000 at press, +20, +28, +36, +44. Holding A for 50 cycles gives a single 5'b11100.

Source files
------------

// File: rtl/numpad_pkg.sv
// Shared types, key codes and small helpers for the 4x4 numpad scanner.
package numpad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } scan_state_e;

  localparam logic [4:0] KEY_NONE = 5'b00000;
  localparam logic [4:0] KEY_EQ   = 5'b11100;
  localparam logic [4:0] KEY_ADD  = 5'b11101;
  localparam logic [4:0] KEY_SUB  = 5'b11110;
  localparam logic [4:0] KEY_MUL  = 5'b11111;

  // Valid flag on top, then column index, then row index
  function automatic logic [4:0] key_code(input logic [1:0] col, input logic [1:0] row);
    return {1'b1, col, row};
  endfunction

  // Lowest-numbered row pulled low wins when several rows are low together
  function automatic logic [1:0] lowest_low(input logic [3:0] pattern);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!pattern[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Active-low one-cold column drive for a column index
  function automatic logic [3:0] column_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones so that
// idle (pulled-up) lines read as inactive straight out of reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Shift the raw input through two stages to settle metastability
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/numpad_scanner.sv
// 4x4 numpad matrix scanner: drives one column low at a time, debounces press
// and release, and emits a single-cycle 5-bit key code per keystroke.
// Optional auto-repeat for digit keys is built when NUMPAD_AUTOREPEAT_EN is defined.
module numpad_scanner
  import numpad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [4:0] value
);

  localparam int unsigned CNT_MAX = max_of(max_of(SETTLE_CYCLES, DEBOUNCE_CYCLES),
                                           max_of(REPEAT_DELAY, REPEAT_PERIOD));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       w_rowsSync;
  logic             w_allHigh;
  logic             w_repeatFire;

  scan_state_e      r_state;
  logic [1:0]       r_colIdx;
  logic [3:0]       r_columns;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_pattern;
  logic [1:0]       r_rowIdx;
  logic [4:0]       r_value;

  sync_2ff #(.WIDTH(4)) u_rowsSync (
    .i_clock (clock),
    .i_reset (reset),
    .i_d     (rows),
    .o_q     (w_rowsSync)
  );

  assign w_allHigh = (w_rowsSync == 4'b1111);

  // Scan/debounce state machine; columns and value are registered here
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= SCAN;
      r_colIdx  <= 2'd0;
      r_columns <= 4'b1110;
      r_cnt     <= '0;
      r_pattern <= 4'b1111;
      r_rowIdx  <= 2'd0;
      r_value   <= KEY_NONE;
    end else begin
      r_value <= KEY_NONE;
      case (r_state)
        SCAN: begin
          if (r_cnt != SETTLE_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (w_allHigh) begin
            r_colIdx  <= r_colIdx + 2'd1;
            r_columns <= column_drive(r_colIdx + 2'd1);
            r_cnt     <= '0;
          end else begin
            r_pattern <= w_rowsSync;
            r_rowIdx  <= lowest_low(w_rowsSync);
            r_cnt     <= '0;
            r_state   <= DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (w_allHigh) begin
            r_cnt   <= '0;
            r_state <= SCAN;
          end else if (w_rowsSync != r_pattern) begin
            r_pattern <= w_rowsSync;
            r_rowIdx  <= lowest_low(w_rowsSync);
            r_cnt     <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_value <= key_code(r_colIdx, r_rowIdx);
            r_cnt   <= '0;
            r_state <= HELD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HELD: begin
          if (w_allHigh) begin
            r_cnt   <= '0;
            r_state <= DEB_RELEASE;
          end else if (w_repeatFire) begin
            r_value <= key_code(r_colIdx, r_rowIdx);
          end
        end
        DEB_RELEASE: begin
          if (!w_allHigh) begin
            r_cnt   <= '0;
            r_state <= HELD;
          end else if (r_cnt == DEB_LAST) begin
            r_colIdx  <= r_colIdx + 2'd1;
            r_columns <= column_drive(r_colIdx + 2'd1);
            r_cnt     <= '0;
            r_state   <= SCAN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= SCAN;
        end
      endcase
    end
  end

`ifdef NUMPAD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] r_repCnt;
  logic             r_repeating;
  logic             w_repeatArmed;

  // Only digit keys that are still physically held may repeat
  assign w_repeatArmed = (r_state == HELD) && !w_allHigh && (r_colIdx != 2'd3);
  assign w_repeatFire  = w_repeatArmed &&
                         (r_repCnt == (r_repeating ? PERIOD_LAST : DELAY_LAST));

  // Repeat timer: long first delay, then shorter period; cleared outside HELD
  always_ff @(posedge clock) begin
    if (reset || (r_state != HELD)) begin
      r_repCnt    <= '0;
      r_repeating <= 1'b0;
    end else if (w_repeatFire) begin
      r_repCnt    <= '0;
      r_repeating <= 1'b1;
    end else if (w_repeatArmed) begin
      r_repCnt <= r_repCnt + 1'b1;
    end
  end
`else
  assign w_repeatFire = 1'b0;
`endif

  assign columns = r_columns;
  assign value   = r_value;

endmodule

// File: tb/tb_numpad_scanner.sv
// Randomized, model-checked bench for numpad_scanner with a few fixed
// keystroke scenarios whose outcomes are known by hand.
module tb_numpad_scanner;

  localparam int SETTLE = 2;
  localparam int DEB    = 4;
  localparam int RD     = 20;
  localparam int RP     = 8;
`ifdef NUMPAD_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  localparam int PH_SCAN  = 0;
  localparam int PH_PRESS = 1;
  localparam int PH_HELD  = 2;
  localparam int PH_REL   = 3;

  localparam logic [3:0] SCAN_SEQ [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  localparam int         REP_GAPS [5] = '{0, 20, 28, 36, 44};

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  columns;
  logic [4:0]  value;
  logic [15:0] keys;

  int checks = 0;
  int failures = 0;

  // Model state: timestamps (edge numbers) rather than counters
  int         cyc = 0;
  bit         mValid = 1'b0;
  int         phase;
  int         mCol;
  int         colStart;
  int         patStart;
  int         relStart;
  int         nextRep;
  logic [3:0] mPat;
  logic [3:0] mS1;
  logic [3:0] mS2;
  logic [4:0] mVal;
  logic [4:0] mCode;

  logic [4:0] dutPulses[$];
  int         dutPulseCyc[$];
  logic [4:0] modelPulses[$];

  numpad_scanner #(
    .SETTLE_CYCLES   (SETTLE),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .rows    (rows),
    .columns (columns),
    .value   (value)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key shorts its row to the driven-low column
  always_comb begin
    rows = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!columns[c] && keys[c*4+r]) rows[r] = 1'b0;
  end

  function automatic logic [3:0] modelRows(input int col, input logic [15:0] k);
    logic [3:0] res;
    res = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (k[col*4+r]) res[r] = 1'b0;
    return res;
  endfunction

  function automatic int lowestRow(input logic [3:0] pat);
    for (int r = 0; r < 4; r++)
      if (!pat[r]) return r;
    return 3;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int n);
    keys = k;
    repeat (n) @(negedge clock);
  endtask

  task automatic waitPulse(input string name, input int bound);
    int n;
    n = 0;
    while (value == 5'd0 && n < bound) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(n < bound), 32'h1);
  endtask

  task automatic clearPulses();
    dutPulses.delete();
    dutPulseCyc.delete();
    modelPulses.delete();
  endtask

  task automatic checkPulses(input string name, input int expCount, input logic [4:0] expCode);
    checkOutput({name, " dut count"}, 32'(dutPulses.size()), 32'(expCount));
    checkOutput({name, " model count"}, 32'(modelPulses.size()), 32'(expCount));
    foreach (dutPulses[i]) checkOutput({name, " dut code"}, 32'(dutPulses[i]), 32'(expCode));
    foreach (modelPulses[i]) checkOutput({name, " model code"}, 32'(modelPulses[i]), 32'(expCode));
  endtask

  // Behavioural reference: decides each edge from elapsed time since events
  always @(posedge clock) begin : modelStep
    logic [3:0] rs;
    logic [3:0] phys;
    cyc++;
    phys = modelRows(mCol, keys);
    rs   = mS2;
    mVal = 5'd0;
    if (reset) begin
      mValid   = 1'b1;
      mS1      = 4'b1111;
      mS2      = 4'b1111;
      mCol     = 0;
      colStart = cyc;
      phase    = PH_SCAN;
    end else begin
      mS2 = mS1;
      mS1 = phys;
      if (phase == PH_SCAN) begin
        if (cyc - colStart == SETTLE + 1) begin
          if (rs == 4'b1111) begin
            mCol     = (mCol + 1) % 4;
            colStart = cyc;
          end else begin
            phase    = PH_PRESS;
            mPat     = rs;
            patStart = cyc;
          end
        end
      end else if (phase == PH_PRESS) begin
        if (rs == 4'b1111) begin
          phase    = PH_SCAN;
          colStart = cyc;
        end else if (rs != mPat) begin
          mPat     = rs;
          patStart = cyc;
        end else if (cyc - patStart == DEB) begin
          mCode   = 5'(16 + mCol * 4 + lowestRow(mPat));
          mVal    = mCode;
          phase   = PH_HELD;
          nextRep = cyc + RD;
        end
      end else if (phase == PH_HELD) begin
        if (rs == 4'b1111) begin
          phase    = PH_REL;
          relStart = cyc;
        end else if (AUTOREP && mCol != 3 && cyc == nextRep) begin
          mVal    = mCode;
          nextRep = cyc + RP;
        end
      end else begin
        if (rs != 4'b1111) begin
          phase   = PH_HELD;
          nextRep = cyc + RD;
        end else if (cyc - relStart == DEB) begin
          mCol     = (mCol + 1) % 4;
          colStart = cyc;
          phase    = PH_SCAN;
        end
      end
    end
    if (mVal != 5'd0) modelPulses.push_back(mVal);
  end

  // Cycle-by-cycle comparison of both outputs against the model
  always @(negedge clock) begin
    if (mValid) begin
      checkOutput("columns", 32'(columns), 32'(4'b1111 ^ (4'b0001 << mCol)));
      checkOutput("value", 32'(value), 32'(mVal));
      if (value != 5'd0) begin
        dutPulses.push_back(value);
        dutPulseCyc.push_back(cyc);
      end
    end
  end

  initial begin
    int n;
    keys  = 16'h0000;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset columns", 32'(columns), 32'h0000000e);
    checkOutput("reset value", 32'(value), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clock);
      checkOutput("scan order", 32'(columns), 32'(SCAN_SEQ[i]));
    end

    // Single clean press of key 1
    clearPulses();
    keys = 16'h0001;
    waitPulse("key1 detect", 60);
    applyStimulus(16'h0001, 5);
    applyStimulus(16'h0000, 30);
    checkPulses("key1", 1, 5'b10000);

    // Key D with contact bounce before settling
    clearPulses();
    applyStimulus(16'h8000, 2);
    applyStimulus(16'h0000, 1);
    applyStimulus(16'h8000, 3);
    applyStimulus(16'h0000, 2);
    applyStimulus(16'h8000, 1);
    applyStimulus(16'h0000, 1);
    keys = 16'h8000;
    waitPulse("keyD detect", 60);
    applyStimulus(16'h8000, 5);
    applyStimulus(16'h0000, 30);
    checkPulses("keyD", 1, 5'b11111);

    // Keys 5 and 8 together, then 5 released while 8 stays down
    clearPulses();
    keys = 16'h0060;
    waitPulse("key5+8 detect", 60);
    applyStimulus(16'h0060, 3);
    applyStimulus(16'h0040, 8);
    applyStimulus(16'h0000, 30);
    checkPulses("key5+8", 1, 5'b10101);

    // Fresh press of 8 alone
    clearPulses();
    keys = 16'h0040;
    waitPulse("key8 detect", 60);
    applyStimulus(16'h0040, 3);
    applyStimulus(16'h0000, 30);
    checkPulses("key8", 1, 5'b10110);

    // Reset while key 9 is being debounced
    clearPulses();
    keys = 16'h0400;
    n = 0;
    while (phase != PH_PRESS && n < 60) begin
      @(negedge clock);
      n++;
    end
    checkOutput("key9 reach debounce", 32'(n < 60), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midpress reset columns", 32'(columns), 32'h0000000e);
    checkOutput("midpress reset value", 32'(value), 32'h0);
    checkOutput("midpress no pulse", 32'(dutPulses.size()), 32'h0);
    reset = 1'b0;
    waitPulse("key9 redetect", 60);
    checkOutput("key9 column", 32'(columns), 32'(4'b1011));
    applyStimulus(16'h0400, 3);
    applyStimulus(16'h0000, 30);
    checkPulses("key9", 1, 5'b11010);

    // Long hold of digit 1
    clearPulses();
    keys = 16'h0001;
    waitPulse("key1 long detect", 60);
    applyStimulus(16'h0001, 47);
    applyStimulus(16'h0000, 30);
`ifdef NUMPAD_AUTOREPEAT_EN
    checkPulses("key1 repeat", 5, 5'b10000);
    for (int i = 1; i < 5; i++)
      if (i < dutPulseCyc.size())
        checkOutput("repeat gap", 32'(dutPulseCyc[i] - dutPulseCyc[0]), 32'(REP_GAPS[i]));
`else
    checkPulses("key1 long", 1, 5'b10000);
`endif

    // Long hold of operator A never repeats
    clearPulses();
    keys = 16'h1000;
    waitPulse("keyA long detect", 60);
    applyStimulus(16'h1000, 47);
    applyStimulus(16'h0000, 30);
    checkPulses("keyA long", 1, 5'b11100);

    // Randomized keystrokes, bounces and occasional resets
    for (int ep = 0; ep < 30; ep++) begin
      logic [15:0] k;
      logic [15:0] one16;
      int hold;
      one16 = 16'h0001;
      k = one16 << $urandom_range(15, 0);
      if ($urandom_range(1, 0) == 1) k = k | (one16 << $urandom_range(15, 0));
      if ($urandom_range(2, 0) == 0) begin
        for (int b = 0; b < 3; b++) begin
          applyStimulus(k, $urandom_range(3, 1));
          applyStimulus(16'h0000, $urandom_range(3, 1));
        end
      end
      hold = $urandom_range(60, 5);
      if ($urandom_range(9, 0) == 0) begin
        applyStimulus(k, hold / 2);
        reset = 1'b1;
        applyStimulus(k, 1);
        reset = 1'b0;
        applyStimulus(k, hold / 2);
      end else begin
        applyStimulus(k, hold);
      end
      applyStimulus(16'h0000, $urandom_range(40, 5));
    end

    repeat (20) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
